// File: rtl/trng_pkg.sv
// Shared types and default sizing for the TRNG post-processing path.
package trng_pkg;

    typedef logic [7:0] byte_t;

    localparam int unsigned TRNG_FIFO_DEPTH = 16;
    localparam int unsigned TRNG_RCT_CUTOFF = 4;

endpackage

// File: rtl/rand_byte_fifo_if.sv
// Byte-stream bundle: collector strobe in, valid/ready head out, status flags.
interface rand_byte_fifo_if
    import trng_pkg::*;
#(
    parameter int unsigned DEPTH = TRNG_FIFO_DEPTH
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             byte_ready;
    byte_t            rand_byte;
    logic             m_valid;
    byte_t            m_data;
    logic             m_ready;
    logic [CNT_W-1:0] level;
    logic             overflow;
    logic             health_fail;
    logic             clear;

    modport master (
        output byte_ready, rand_byte, m_ready, clear,
        input  m_valid, m_data, level, overflow, health_fail
    );

    modport slave (
        input  byte_ready, rand_byte, m_ready, clear,
        output m_valid, m_data, level, overflow, health_fail
    );

endinterface

// File: rtl/rct_health_test.sv
// Repetition-count health test over a byte stream.
module rct_health_test
    import trng_pkg::*;
#(
    parameter  int unsigned RCT_CUTOFF = TRNG_RCT_CUTOFF,
    localparam int unsigned RUN_W      = $clog2(RCT_CUTOFF + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  byte_t            in_byte,
    output logic             fail_next,
    output logic [RUN_W-1:0] run_count
);
    byte_t            last_byte_q, last_byte_d;
    logic             last_valid_q, last_valid_d;
    logic [RUN_W-1:0] run_q, run_d;

    // Next run state: clear restarts first so a same-cycle byte begins a fresh run.
    always_comb begin
        last_byte_d  = last_byte_q;
        last_valid_d = last_valid_q;
        run_d        = run_q;
        if (clear) begin
            last_valid_d = 1'b0;
            run_d        = '0;
        end
        if (in_valid) begin
            if (last_valid_d && (in_byte == last_byte_q)) begin
                if (run_d < RUN_W'(RCT_CUTOFF)) begin
                    run_d = run_d + RUN_W'(1);
                end
            end else begin
                run_d        = RUN_W'(1);
                last_byte_d  = in_byte;
                last_valid_d = 1'b1;
            end
        end
        fail_next = in_valid && (run_d >= RUN_W'(RCT_CUTOFF));
    end

    // Run-tracking registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_byte_q  <= '0;
            last_valid_q <= 1'b0;
            run_q        <= '0;
        end else begin
            last_byte_q  <= last_byte_d;
            last_valid_q <= last_valid_d;
            run_q        <= run_d;
        end
    end

    assign run_count = run_q;

endmodule

// File: rtl/rand_byte_fifo.sv
// Show-ahead byte FIFO gated by a repetition-count health test.
module rand_byte_fifo
    import trng_pkg::*;
#(
    parameter int unsigned DEPTH      = TRNG_FIFO_DEPTH,
    parameter int unsigned RCT_CUTOFF = TRNG_RCT_CUTOFF
) (
    input  logic                 clk,
    input  logic                 rst,
    rand_byte_fifo_if.slave      bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    byte_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             hf_q, hf_d;

    logic             trip;
    logic             valid;
    logic             pop;
    logic             full;
    logic             wr_en;

    rct_health_test #(
        .RCT_CUTOFF (RCT_CUTOFF)
    ) u_rct (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.clear),
        .in_valid  (bus.byte_ready),
        .in_byte   (bus.rand_byte),
        .fail_next (trip),
        .run_count ()
    );

    assign valid = (level_q != '0) && !hf_q;
    assign pop   = valid && bus.m_ready;
    assign full  = (level_q == CNT_W'(DEPTH));
    // A trip takes the byte; a stale fail flag blocks writes unless cleared this cycle.
    assign wr_en = bus.byte_ready && !trip && !(hf_q && !bus.clear) && (!full || pop);

    // Pointer, level and flag next-state; a trip flushes and voids any pop.
    always_comb begin
        wr_d       = wr_q;
        rd_d       = rd_q;
        level_d    = level_q;
        overflow_d = (overflow_q && !bus.clear) || (bus.byte_ready && full && !pop);
        hf_d       = (hf_q && !bus.clear) || trip;
        if (trip) begin
            wr_d    = '0;
            rd_d    = '0;
            level_d = '0;
        end else begin
            if (wr_en) begin
                wr_d = wr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_d = rd_q + PTR_W'(1);
            end
            if (wr_en && !pop) begin
                level_d = level_q + CNT_W'(1);
            end else if (pop && !wr_en) begin
                level_d = level_q - CNT_W'(1);
            end
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= '0;
            rd_q       <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            hf_q       <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            hf_q       <= hf_d;
        end
    end

    // Storage array; contents past the level are never presented.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_q] <= bus.rand_byte;
        end
    end

    assign bus.m_valid     = valid;
    assign bus.m_data      = valid ? mem[rd_q] : '0;
    assign bus.level       = level_q;
    assign bus.overflow    = overflow_q;
    assign bus.health_fail = hf_q;

endmodule

// File: tb/tb_rand_byte_fifo.sv
// Bench for rand_byte_fifo: directed scenarios plus a randomized run against a queue model.
module tb_rand_byte_fifo;
    import trng_pkg::*;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned CUTOFF = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    rand_byte_fifo_if #(.DEPTH(DEPTH)) bus ();

    rand_byte_fifo #(
        .DEPTH      (DEPTH),
        .RCT_CUTOFF (CUTOFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    byte_t       mq[$];
    bit          m_ovf;
    bit          m_hf;
    bit          m_lv;
    byte_t       m_lb;
    int unsigned m_run;

    function automatic void model_step(input bit r, input bit br, input byte_t b,
                                       input bit mr, input bit clr);
        bit do_pop;
        bit trip;
        bit ovf_evt;
        if (r) begin
            mq.delete();
            m_ovf = 0; m_hf = 0; m_lv = 0; m_run = 0; m_lb = '0;
            return;
        end
        do_pop  = (mq.size() != 0) && !m_hf && mr;
        ovf_evt = br && (mq.size() == DEPTH) && !do_pop;
        if (clr) begin
            m_ovf = 0; m_hf = 0; m_lv = 0; m_run = 0;
        end
        trip = 0;
        if (br) begin
            if (m_lv && b == m_lb) begin
                m_run = (m_run + 1 > CUTOFF) ? CUTOFF : m_run + 1;
            end else begin
                m_run = 1; m_lb = b; m_lv = 1;
            end
            trip = (m_run >= CUTOFF);
        end
        if (trip) begin
            m_hf = 1;
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (br && !m_hf && mq.size() < DEPTH) mq.push_back(b);
        end
        if (ovf_evt) m_ovf = 1;
    endfunction

    function automatic logic [15:0] exp_vec();
        bit    mv;
        byte_t d;
        mv = (mq.size() != 0) && !m_hf;
        d  = mv ? mq[0] : 8'h00;
        return {mv, d, 5'(mq.size()), m_ovf, m_hf};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {bus.m_valid, bus.m_data, bus.level, bus.overflow, bus.health_fail};
    endfunction

    task automatic tick(input bit r, input bit br, input byte_t b, input bit mr, input bit clr);
        rst            = r;
        bus.byte_ready = br;
        bus.rand_byte  = b;
        bus.m_ready    = mr;
        bus.clear      = clr;
        @(posedge clk);
        model_step(r, br, b, mr, clr);
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(1, 1, 8'hEE, 1, 0);
        tick(1, 1, 8'hEE, 1, 0);
        n_checks++;
        if (dut_vec() !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(), 16'h0000);
        end
        tick(0, 0, 8'h00, 0, 0);
    endtask

    task automatic test_order();
        byte_t seq [3] = '{8'h11, 8'h22, 8'h33};
        tick(0, 1, seq[0], 0, 0);
        n_checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h11) begin
            n_fail++;
            $display("FAIL order_latency: got v=%b d=%h expected v=1 d=11", bus.m_valid, bus.m_data);
        end
        tick(0, 1, seq[1], 0, 0);
        tick(0, 1, seq[2], 0, 0);
        n_checks++;
        if (bus.level !== 5'd3) begin
            n_fail++;
            $display("FAIL order_level: got %0d expected 3", bus.level);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== seq[i]) begin
                n_fail++;
                $display("FAIL order_data%0d: got v=%b d=%h expected v=1 d=%h", i, bus.m_valid, bus.m_data, seq[i]);
            end
            tick(0, 0, 8'h00, 1, 0);
        end
        n_checks++;
        if (bus.m_valid !== 1'b0 || bus.level !== 5'd0 || bus.m_data !== 8'h00) begin
            n_fail++;
            $display("FAIL order_empty: got v=%b lvl=%0d d=%h expected v=0 lvl=0 d=00", bus.m_valid, bus.level, bus.m_data);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) tick(0, 1, byte_t'(i), 0, 0);
        tick(0, 1, 8'hAA, 0, 0);
        n_checks++;
        if (bus.level !== 5'd16 || bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set: got lvl=%0d ovf=%b expected lvl=16 ovf=1", bus.level, bus.overflow);
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== byte_t'(i)) begin
                n_fail++;
                $display("FAIL overflow_drain%0d: got v=%b d=%h expected v=1 d=%h", i, bus.m_valid, bus.m_data, byte_t'(i));
            end
            tick(0, 0, 8'h00, 1, 0);
        end
        n_checks++;
        if (bus.m_valid !== 1'b0 || bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_after_drain: got v=%b ovf=%b expected v=0 ovf=1", bus.m_valid, bus.overflow);
        end
        tick(0, 0, 8'h00, 0, 1);
        n_checks++;
        if (bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clear: got %b expected 0", bus.overflow);
        end
    endtask

    task automatic test_full_rw();
        byte_t last;
        for (int i = 0; i < 16; i++) tick(0, 1, byte_t'(8'h40 + i), 0, 0);
        tick(0, 1, 8'hC3, 1, 0);
        n_checks++;
        if (bus.level !== 5'd16 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_rw_level: got lvl=%0d ovf=%b expected lvl=16 ovf=0", bus.level, bus.overflow);
        end
        last = 8'h00;
        for (int i = 0; i < 16; i++) begin
            last = bus.m_data;
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL full_rw_drain%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
            tick(0, 0, 8'h00, 1, 0);
        end
        n_checks++;
        if (last !== 8'hC3) begin
            n_fail++;
            $display("FAIL full_rw_16th: got %h expected c3", last);
        end
    endtask

    task automatic test_rct();
        byte_t pat [8] = '{8'h5A, 8'h5A, 8'h5A, 8'h5B, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        tick(0, 1, 8'h70, 0, 0);
        tick(0, 1, 8'h71, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 1, pat[i], 0, 0);
        n_checks++;
        if (bus.health_fail !== 1'b0 || bus.level !== 5'd6) begin
            n_fail++;
            $display("FAIL rct_no_trip: got hf=%b lvl=%0d expected hf=0 lvl=6", bus.health_fail, bus.level);
        end
        for (int i = 4; i < 7; i++) tick(0, 1, pat[i], 0, 0);
        n_checks++;
        if (bus.health_fail !== 1'b0 || bus.level !== 5'd9) begin
            n_fail++;
            $display("FAIL rct_pre_trip: got hf=%b lvl=%0d expected hf=0 lvl=9", bus.health_fail, bus.level);
        end
        tick(0, 1, pat[7], 1, 0);
        n_checks++;
        if (bus.health_fail !== 1'b1 || bus.level !== 5'd0 || bus.m_valid !== 1'b0 || bus.m_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rct_trip: got hf=%b lvl=%0d v=%b d=%h expected hf=1 lvl=0 v=0 d=00",
                     bus.health_fail, bus.level, bus.m_valid, bus.m_data);
        end
        tick(0, 1, 8'h99, 1, 0);
        tick(0, 1, 8'h98, 1, 0);
        n_checks++;
        if (bus.health_fail !== 1'b1 || bus.level !== 5'd0 || bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rct_ignored: got hf=%b lvl=%0d v=%b expected hf=1 lvl=0 v=0", bus.health_fail, bus.level, bus.m_valid);
        end
        tick(0, 0, 8'h00, 0, 1);
        tick(0, 1, 8'h01, 0, 0);
        n_checks++;
        if (bus.health_fail !== 1'b0 || bus.level !== 5'd1 || bus.m_data !== 8'h01) begin
            n_fail++;
            $display("FAIL rct_recover: got hf=%b lvl=%0d d=%h expected hf=0 lvl=1 d=01", bus.health_fail, bus.level, bus.m_data);
        end
        // clear together with a byte: the byte starts a fresh run and is stored
        for (int i = 0; i < 3; i++) tick(0, 1, 8'h01, 0, 0);
        tick(0, 1, 8'h01, 0, 1);
        n_checks++;
        if (dut_vec() !== exp_vec() || bus.health_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL rct_clear_with_byte: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 40 && mq.size() != 0; i++) tick(0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 5; i++) tick(0, 1, byte_t'(8'h80 + i), 0, 0);
        n_checks++;
        if (bus.level !== 5'd5) begin
            n_fail++;
            $display("FAIL reset_mid_fill: got lvl=%0d expected 5", bus.level);
        end
        tick(1, 1, 8'hE7, 0, 0);
        n_checks++;
        if (bus.level !== 5'd0 || bus.m_valid !== 1'b0 || bus.m_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid: got lvl=%0d v=%b d=%h expected lvl=0 v=0 d=00", bus.level, bus.m_valid, bus.m_data);
        end
        tick(0, 0, 8'h00, 1, 0);
        n_checks++;
        if (bus.level !== 5'd0 || bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_after: got lvl=%0d v=%b expected lvl=0 v=0", bus.level, bus.m_valid);
        end
    endtask

    task automatic test_random();
        bit    r, br, mr, clr;
        byte_t b;
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 199) == 0);
            br  = ($urandom_range(0, 99) < 65);
            mr  = ($urandom_range(0, 99) < 40);
            clr = ($urandom_range(0, 24) == 0);
            b   = byte_t'($urandom_range(0, 3));
            tick(r, br, b, mr, clr);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.byte_ready = 1'b0;
        bus.rand_byte  = '0;
        bus.m_ready    = 1'b0;
        bus.clear      = 1'b0;
        @(negedge clk);
        test_reset();
        test_order();
        test_overflow();
        test_full_rw();
        test_rct();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rand_byte_fifo.md
Name: rand_byte_fifo

Overview:
Downstream of the bit collector. Takes each byte_ready/rand_byte pulse and runs a repetition-count health test (RCT) on the byte stream. Buffers passing bytes in a show-ahead FIFO and presents them to the consumer (UART/host bridge) over a valid/ready interface. Reports sticky overflow and health-failure flags.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
RCT_CUTOFF, 4, count of consecutive identical input bytes that trips health_fail; >= 2
CNT_W, derived $clog2(DEPTH)+1 (localparam), width of level

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
byte_ready  in  1  one-cycle strobe: rand_byte holds a new byte
rand_byte  in  8  random byte from the collector
m_valid  out  1  m_data holds the head byte
m_data  out  8  head-of-FIFO byte; 0 when m_valid=0
m_ready  in  1  consumer accepts the head byte when m_valid && m_ready
level  out  CNT_W  number of stored bytes, 0..DEPTH
overflow  out  1  sticky: a byte was dropped because the FIFO was full
health_fail  out  1  sticky: RCT tripped
clear  in  1  one-cycle pulse: clears the sticky flags and restarts the RCT

Behaviour:
- Reset, sync, dominates all inputs: rd/wr pointers=0, level=0, m_valid=0, m_data=0, overflow=0, health_fail=0, RCT run_count=0, last_valid=0.
- Read: pop when m_valid && m_ready. m_valid = (level!=0) && !health_fail.
- Write condition: byte_ready && !health_fail_next && (level<DEPTH || pop this cycle).
- Full with simultaneous pop: the write is accepted, level stays DEPTH, overflow is not set.
- Latency: a byte written into an empty FIFO shows m_valid=1 on the next cycle. There is no combinational path from byte_ready to m_valid.
- level: +1 on write-only, -1 on pop-only, unchanged on both or neither. Pointers wrap modulo DEPTH.
- Overflow: byte_ready with level==DEPTH and no pop. The byte is dropped and overflow is set to 1 on the next edge. The RCT still evaluates the dropped byte.
- RCT, evaluated on every byte_ready whether or not the byte is stored:
  - If last_valid && rand_byte==last_byte, then run_count <= run_count+1, saturating at RCT_CUTOFF.
  - Otherwise run_count <= 1, last_byte <= rand_byte, last_valid <= 1.
  - health_fail_next = (new run_count >= RCT_CUTOFF).
- On a trip:
  - health_fail <= 1 and the FIFO is flushed on the same edge: pointers=0, level=0.
  - The tripping byte is not stored, and any pop in that cycle is void.
  - While health_fail=1, no writes occur and m_valid=0. The RCT keeps tracking.
- Clear (lower priority than rst):
  - overflow <= 0, health_fail <= 0, last_valid <= 0, run_count <= 0.
  - FIFO contents are untouched (the FIFO is already empty after a trip).
  - clear and byte_ready in the same cycle: the byte is processed against the restarted RCT (run_count=1, last_byte=byte) and written if there is space. Flags end at 0 unless that byte itself causes an overflow.
- Reset mid-operation: all stored data is discarded and the outputs take their reset values on the next edge.
- No X on outputs. m_data is forced to 0 whenever m_valid=0.

Decomposition:
- Shared package trng_pkg:
  - typedef logic [7:0] byte_t
  - default constants TRNG_FIFO_DEPTH=16 and TRNG_RCT_CUTOFF=4
- One sub-module, rct_health_test (clk, rst, clear, in_valid, in_byte, fail_next, run_count). It holds last_byte/run_count and is reusable on other byte streams.
- FIFO storage and pointers stay inline in rand_byte_fifo.

Test Plan:
- Reset: assert rst for 2 cycles with byte_ready=1 -> m_valid=0, m_data=0, level=0, overflow=0, health_fail=0.
- Ordering and latency: write 0x11, 0x22, 0x33 on consecutive cycles with m_ready=0 -> m_valid=1 from the cycle after 0x11, level=3. Then set m_ready=1 -> m_data reads 0x11, 0x22, 0x33 on three cycles, then m_valid=0, level=0.
- Overflow: write 16 distinct bytes 0x00..0x0F with m_ready=0, then 0xAA -> level=16, overflow=1, and the drain returns exactly 0x00..0x0F. A later clear -> overflow=0.
- Full with simultaneous read/write: FIFO at 16, byte_ready=1 (0xC3) and m_ready=1 in the same cycle -> level stays 16, overflow=0, and 0xC3 emerges 16th after the current head.
- RCT, CUTOFF=4, with 2 bytes queued:
  - Sequence 0x5A, 0x5A, 0x5A, 0x5B -> no trip.
  - Then 0x5A x4 -> health_fail=1 after the 4th strobe, level=0, m_valid=0; further bytes are ignored.
  - clear, then 0x01 -> health_fail=0, level=1.
- Reset mid-stream with level=5 and byte_ready=1 -> next cycle level=0, m_valid=0, and the byte presented with rst is not stored.
